// File: rtl/regfile_wr_arbiter_if.sv
// Register-file write-port bundle: CPU writeback, DMA write request and the
// arbitrated write port, with master (requesters) and slave (arbiter) views.
interface regfile_wr_arbiter_if #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_dir;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_stall;
    logic              dma_valid;
    logic [ADDR_W-1:0] dma_dir;
    logic [DATA_W-1:0] dma_data;
    logic              dma_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_dir;
    logic [DATA_W-1:0] rf_data;
    logic [CNT_W-1:0]  dma_count;

    modport master (
        output cpu_we, cpu_dir, cpu_data, dma_valid, dma_dir, dma_data,
        input  cpu_stall, dma_ready, rf_we, rf_dir, rf_data, dma_count
    );

    modport slave (
        input  cpu_we, cpu_dir, cpu_data, dma_valid, dma_dir, dma_data,
        output cpu_stall, dma_ready, rf_we, rf_dir, rf_data, dma_count
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between CPU writeback (priority) and a
// queued DMA engine, with an anti-starvation timer that forces a CPU stall.
module regfile_wr_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8
) (
    input logic             clk,
    input logic             rst_n,
    regfile_wr_arbiter_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FORCE
    } state_t;

    // Reset asserts immediately but releases only after two clock edges.
    logic [1:0] rst_sync;
    logic       arst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign arst_n = rst_sync[1];

    logic [ADDR_W-1:0] q_dir  [FIFO_DEPTH];
    logic [DATA_W-1:0] q_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count, count_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    state_t            state, state_next;

    logic              push, pop, q_empty, force_due;
    logic              grant;
    logic [ADDR_W-1:0] grant_dir;
    logic [DATA_W-1:0] grant_data;

    logic              rf_we_q, cpu_stall_q;
    logic [ADDR_W-1:0] rf_dir_q;
    logic [DATA_W-1:0] rf_data_q;

    assign q_empty = (count == '0);
    assign push    = bus.dma_valid && (count != CNT_W'(FIFO_DEPTH));

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        pop        = 1'b0;
        grant      = 1'b0;
        grant_dir  = '0;
        grant_data = '0;
        force_due  = 1'b0;
        state_next = state;
        wait_next  = wait_cnt;
        count_next = count;

        if (state == ST_FORCE) begin
            if (!q_empty) begin
                pop        = 1'b1;
                grant      = 1'b1;
                grant_dir  = q_dir[rd_ptr];
                grant_data = q_data[rd_ptr];
            end
        end else if (bus.cpu_we) begin
            grant      = 1'b1;
            grant_dir  = bus.cpu_dir;
            grant_data = bus.cpu_data;
        end else if (!q_empty) begin
            pop        = 1'b1;
            grant      = 1'b1;
            grant_dir  = q_dir[rd_ptr];
            grant_data = q_data[rd_ptr];
        end

        if (push && !pop)      count_next = count + CNT_W'(1);
        else if (!push && pop) count_next = count - CNT_W'(1);

        force_due = (state == ST_WAIT) && !q_empty && !pop &&
                    (wait_cnt == WAIT_W'(MAX_WAIT - 1));

        // The timer measures how long the current head has been eligible.
        if (pop || q_empty || force_due) wait_next = '0;
        else                             wait_next = wait_cnt + WAIT_W'(1);

        unique case (state)
            ST_IDLE:  if (count_next != '0) state_next = ST_WAIT;
            ST_WAIT: begin
                if (force_due)              state_next = ST_FORCE;
                else if (count_next == '0)  state_next = ST_IDLE;
            end
            ST_FORCE: state_next = (count_next != '0) ? ST_WAIT : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // NOTE: queue storage has no reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            q_dir[wr_ptr]  <= bus.dma_dir;
            q_data[wr_ptr] <= bus.dma_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            count    <= count_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Register 0 is hardwired zero, so a write there is dropped at the port.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rf_we_q     <= 1'b0;
            rf_dir_q    <= '0;
            rf_data_q   <= '0;
            cpu_stall_q <= 1'b0;
        end else begin
            rf_we_q     <= grant && (grant_dir != '0);
            cpu_stall_q <= (state_next == ST_FORCE);
            if (grant) begin
                rf_dir_q  <= grant_dir;
                rf_data_q <= grant_data;
            end
        end
    end

    assign bus.rf_we     = rf_we_q;
    assign bus.rf_dir    = rf_dir_q;
    assign bus.rf_data   = rf_data_q;
    assign bus.cpu_stall = cpu_stall_q;
    assign bus.dma_count = count;
    assign bus.dma_ready = (count != CNT_W'(FIFO_DEPTH));
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomised and directed bench for regfile_wr_arbiter against a queue-based
// reference model of the write-port sharing rules.
module tb_regfile_wr_arbiter;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_WAIT   = 8;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] dir;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int tests = 0;
    int fails = 0;

    // Reference model: in-order queue, head age, and expected write port.
    wr_t               mq[$];
    int                head_wait = 0;
    logic              exp_we    = 1'b0;
    logic [ADDR_W-1:0] exp_dir   = '0;
    logic [DATA_W-1:0] exp_data  = '0;

    regfile_wr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    regfile_wr_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic bit model_force();
        return (mq.size() > 0) && (head_wait == MAX_WAIT);
    endfunction

    task automatic model_clear();
        mq.delete();
        head_wait = 0;
        exp_we    = 1'b0;
        exp_dir   = '0;
        exp_data  = '0;
    endtask

    task automatic model_step(input logic we, input logic [ADDR_W-1:0] cd, input logic [DATA_W-1:0] cdat,
                              input logic v, input logic [ADDR_W-1:0] dd, input logic [DATA_W-1:0] ddat);
        int  pre_size;
        bit  forced, popped, granted, can_push;
        wr_t g;
        pre_size = mq.size();
        forced   = model_force();
        can_push = v && (pre_size < FIFO_DEPTH);
        popped   = 0;
        granted  = 0;
        g        = '0;
        if (forced) begin
            g = mq.pop_front(); popped = 1; granted = 1;
        end else if (we) begin
            g.dir = cd; g.data = cdat; granted = 1;
        end else if (pre_size > 0) begin
            g = mq.pop_front(); popped = 1; granted = 1;
        end
        if (popped || pre_size == 0) head_wait = 0;
        else                         head_wait = head_wait + 1;
        if (can_push) mq.push_back('{dir: dd, data: ddat});
        exp_we = granted && (g.dir != '0);
        if (granted) begin
            exp_dir  = g.dir;
            exp_data = g.data;
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare the
    // registered status, step the model, then compare the write port.
    task automatic tick(input logic we, input logic [ADDR_W-1:0] cd, input logic [DATA_W-1:0] cdat,
                        input logic v, input logic [ADDR_W-1:0] dd, input logic [DATA_W-1:0] ddat,
                        output logic stall_seen);
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_stall;
        bus.cpu_we    = we;
        bus.cpu_dir   = cd;
        bus.cpu_data  = cdat;
        bus.dma_valid = v;
        bus.dma_dir   = dd;
        bus.dma_data  = ddat;
        #1;
        exp_cnt   = CNT_W'(mq.size());
        exp_stall = model_force();
        stall_seen = bus.cpu_stall;
        tests++;
        if (bus.cpu_stall !== exp_stall) begin
            fails++;
            $display("FAIL cpu_stall: got %b expected %b at %0t", bus.cpu_stall, exp_stall, $time);
        end
        tests++;
        if (bus.dma_count !== exp_cnt) begin
            fails++;
            $display("FAIL dma_count: got %0d expected %0d at %0t", bus.dma_count, exp_cnt, $time);
        end
        tests++;
        if (bus.dma_ready !== (exp_cnt != CNT_W'(FIFO_DEPTH))) begin
            fails++;
            $display("FAIL dma_ready: got %b expected %b at %0t", bus.dma_ready,
                     exp_cnt != CNT_W'(FIFO_DEPTH), $time);
        end
        model_step(we, cd, cdat, v, dd, ddat);
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus.rf_we !== exp_we) begin
            fails++;
            $display("FAIL rf_we: got %b expected %b at %0t", bus.rf_we, exp_we, $time);
        end
        tests++;
        if (bus.rf_dir !== exp_dir || bus.rf_data !== exp_data) begin
            fails++;
            $display("FAIL rf_port: got %0d/%h expected %0d/%h at %0t",
                     bus.rf_dir, bus.rf_data, exp_dir, exp_data, $time);
        end
    endtask

    task automatic idle_tick();
        logic s;
        tick(1'b0, '0, '0, 1'b0, '0, '0, s);
    endtask

    task automatic test_reset();
        bus.cpu_we = 1'b0; bus.cpu_dir = '0; bus.cpu_data = '0;
        bus.dma_valid = 1'b0; bus.dma_dir = '0; bus.dma_data = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.rf_we !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.dma_count !== '0 || bus.dma_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: got we=%b stall=%b cnt=%0d rdy=%b expected 0 0 0 1",
                     bus.rf_we, bus.cpu_stall, bus.dma_count, bus.dma_ready);
        end
        tests++;
        if (bus.rf_dir !== '0 || bus.rf_data !== '0) begin
            fails++;
            $display("FAIL reset_port: got %0d/%h expected 0/0", bus.rf_dir, bus.rf_data);
        end
        model_clear();
        rst_n = 1'b1;
        repeat (3) idle_tick();
    endtask

    task automatic test_cpu_write();
        logic s;
        tick(1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, '0, '0, s);
        tests++;
        if (bus.rf_we !== 1'b1 || bus.rf_dir !== 5'd5 || bus.rf_data !== 32'hA5A5_A5A5) begin
            fails++;
            $display("FAIL cpu_write: got %b/%0d/%h expected 1/5/a5a5a5a5", bus.rf_we, bus.rf_dir, bus.rf_data);
        end
        idle_tick();
    endtask

    task automatic test_dma_write();
        logic s;
        tick(1'b0, '0, '0, 1'b1, 5'd3, 32'h11, s);
        tests++;
        if (bus.rf_we !== 1'b0) begin
            fails++;
            $display("FAIL dma_latency_early: got rf_we %b expected 0", bus.rf_we);
        end
        idle_tick();
        tests++;
        if (bus.rf_we !== 1'b1 || bus.rf_dir !== 5'd3 || bus.rf_data !== 32'h11 || bus.dma_count !== '0) begin
            fails++;
            $display("FAIL dma_write: got %b/%0d/%h cnt=%0d expected 1/3/11 cnt=0",
                     bus.rf_we, bus.rf_dir, bus.rf_data, bus.dma_count);
        end
    endtask

    task automatic test_force();
        logic s;
        int   stall_at, stalls;
        stall_at = -1;
        stalls   = 0;
        tick(1'b1, 5'd1, 32'h100, 1'b1, 5'd7, 32'h77, s);
        for (int i = 1; i < 3 * MAX_WAIT; i++) begin
            tick(1'b1, 5'd2, 32'h200 + i, 1'b0, '0, '0, s);
            if (s === 1'b1) begin
                stalls++;
                if (stall_at < 0) begin
                    stall_at = i;
                    tests++;
                    if (bus.rf_we !== 1'b1 || bus.rf_dir !== 5'd7 || bus.rf_data !== 32'h77) begin
                        fails++;
                        $display("FAIL force_grant: got %b/%0d/%h expected 1/7/77", bus.rf_we, bus.rf_dir, bus.rf_data);
                    end
                end
            end
        end
        tests++;
        if (stall_at != MAX_WAIT + 1 || stalls != 1) begin
            fails++;
            $display("FAIL force_timing: got stall at cycle %0d (%0d stalls) expected cycle %0d (1 stall)",
                     stall_at, stalls, MAX_WAIT + 1);
        end
    endtask

    task automatic test_full();
        logic s;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 5'd4, 32'h400 + i, 1'b1, 5'd9, 32'h900 + i, s);
            if (i == 3) begin
                tests++;
                if (bus.dma_ready !== 1'b0 || bus.dma_count !== CNT_W'(FIFO_DEPTH)) begin
                    fails++;
                    $display("FAIL full_ready: got rdy=%b cnt=%0d expected 0/%0d", bus.dma_ready, bus.dma_count, FIFO_DEPTH);
                end
            end
            if (i == MAX_WAIT + 1) begin
                tests++;
                if (bus.dma_count !== CNT_W'(FIFO_DEPTH - 1) || bus.dma_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL full_no_push_on_pop: got cnt=%0d rdy=%b expected %0d/1",
                             bus.dma_count, bus.dma_ready, FIFO_DEPTH - 1);
                end
            end
            if (i == MAX_WAIT + 2) begin
                tests++;
                if (bus.dma_count !== CNT_W'(FIFO_DEPTH)) begin
                    fails++;
                    $display("FAIL full_refill: got cnt=%0d expected %0d", bus.dma_count, FIFO_DEPTH);
                end
            end
        end
        repeat (FIFO_DEPTH + 1) idle_tick();
    endtask

    task automatic test_dir_zero();
        logic s;
        tick(1'b1, 5'd0, 32'hDEAD, 1'b0, '0, '0, s);
        tests++;
        if (bus.rf_we !== 1'b0) begin
            fails++;
            $display("FAIL zero_cpu: got rf_we %b expected 0", bus.rf_we);
        end
        tick(1'b0, '0, '0, 1'b1, 5'd0, 32'hBEEF, s);
        idle_tick();
        tests++;
        if (bus.rf_we !== 1'b0 || bus.dma_count !== '0) begin
            fails++;
            $display("FAIL zero_dma: got rf_we=%b cnt=%0d expected 0/0", bus.rf_we, bus.dma_count);
        end
    endtask

    task automatic test_reset_full();
        logic s;
        for (int i = 0; i < FIFO_DEPTH; i++) tick(1'b1, 5'd6, 32'h600 + i, 1'b1, 5'd12, 32'hC00 + i, s);
        tests++;
        if (bus.dma_ready !== 1'b0) begin
            fails++;
            $display("FAIL prereset_full: got rdy=%b expected 0", bus.dma_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.rf_we !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.dma_count !== '0 || bus.dma_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: got we=%b stall=%b cnt=%0d rdy=%b expected 0 0 0 1",
                     bus.rf_we, bus.cpu_stall, bus.dma_count, bus.dma_ready);
        end
        model_clear();
        bus.cpu_we = 1'b0; bus.dma_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle_tick();
    endtask

    task automatic test_random();
        logic              s, we, v, hold;
        logic [ADDR_W-1:0] cd, dd;
        logic [DATA_W-1:0] cdat, ddat;
        we = 1'b0; cd = '0; cdat = '0;
        hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                we   = ($urandom_range(99) < ((i < 300) ? 60 : 88));
                cd   = ADDR_W'($urandom_range(31));
                cdat = $urandom;
            end
            v    = ($urandom_range(99) < 45);
            dd   = ADDR_W'($urandom_range(7));
            ddat = $urandom;
            hold = model_force() && we;
            tick(we, cd, cdat, v, dd, ddat, s);
        end
        repeat (FIFO_DEPTH + 2) idle_tick();
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_dma_write();
        test_force();
        test_full();
        test_dir_zero();
        test_reset_full();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
